// File: rtl/riscv_core_plic_lite.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_plic_lite
// Description : Minimal platform interrupt controller for the core's
//               machine-external-interrupt handshake. NSRC asynchronous level
//               sources are synchronized and converted to edge-triggered
//               pending bits. The pending bits are masked by an enable
//               register, and the lowest-index active source wins. The
//               controller raises mexternal, claims the winner on the core's
//               1-cycle ack, and re-arms when software writes COMPLETE.
// Ports       :
//   i_riscv_core_clk        core clock (only clock)
//   i_riscv_core_rst        asynchronous active-high reset
//   i_riscv_core_irq_src    NSRC asynchronous level interrupt sources
//   o_riscv_core_mexternal  external interrupt request (mip.MEIP)
//   i_riscv_core_ack        1-cycle acknowledge pulse from the CSR unit
//   i_riscv_core_plic_addr  register word address
//                           (0 PENDING, 1 ENABLE, 2 CLAIM/COMPLETE, 3 STATUS)
//   i_riscv_core_plic_wen   register write enable
//   i_riscv_core_plic_wdata register write data
//   o_riscv_core_plic_rdata registered read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_core_plic_lite #(
    parameter int NSRC        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            i_riscv_core_clk,
    input  logic            i_riscv_core_rst,
    input  logic [NSRC-1:0] i_riscv_core_irq_src,
    output logic            o_riscv_core_mexternal,
    input  logic            i_riscv_core_ack,
    input  logic [1:0]      i_riscv_core_plic_addr,
    input  logic            i_riscv_core_plic_wen,
    input  logic [31:0]     i_riscv_core_plic_wdata,
    output logic [31:0]     o_riscv_core_plic_rdata
);

    localparam int ID_W = $clog2(NSRC + 1);

    localparam logic [1:0] c_ADDR_PENDING = 2'd0;
    localparam logic [1:0] c_ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] c_ADDR_CLAIM   = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [NSRC-1:0] r_sync [SYNC_STAGES];
    logic [NSRC-1:0] r_prev;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_enable;
    logic [ID_W-1:0] r_claim_id;
    state_t          r_state;
    logic            r_mext;
    logic [31:0]     r_rdata;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic [NSRC-1:0] w_synced;
    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_active;
    logic [NSRC-1:0] w_win_oh;
    logic [ID_W-1:0] w_win_idx;
    logic            w_win_any;
    logic            w_found;
    logic            w_claim;
    logic            w_complete;
    logic            w_enable_wr;
    logic            w_unused_wdata;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_edge   = w_synced & ~r_prev;
    assign w_active = r_pending & r_enable;
    assign w_win_any = |w_active;

    // Only the low NSRC bits of write data carry meaning.
    assign w_unused_wdata = ^i_riscv_core_plic_wdata[31:NSRC];

    assign w_enable_wr = i_riscv_core_plic_wen && (i_riscv_core_plic_addr == c_ADDR_ENABLE);
    assign w_complete  = i_riscv_core_plic_wen && (i_riscv_core_plic_addr == c_ADDR_CLAIM);
    // The claim uses the enable value held before any same-cycle ENABLE write.
    assign w_claim     = (r_state == ST_REQ) && i_riscv_core_ack && w_win_any;

    // Fixed priority: lowest active index wins.
    always_comb begin
        w_win_oh  = '0;
        w_win_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_active[i] && !w_found) begin
                w_found     = 1'b1;
                w_win_idx   = ID_W'(i);
                w_win_oh[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Gateway: synchronizer, edge detect, pending bits
    // ------------------------------------------------------------------------
    always_ff @(posedge i_riscv_core_clk or posedge i_riscv_core_rst) begin
        if (i_riscv_core_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_sync[0] <= i_riscv_core_irq_src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= w_synced;
            // A fresh edge on the winner in its claim cycle keeps the bit set.
            r_pending <= (r_pending & ~(w_claim ? w_win_oh : '0)) | w_edge;
        end
    end

    // ------------------------------------------------------------------------
    // Enable register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_riscv_core_clk or posedge i_riscv_core_rst) begin
        if (i_riscv_core_rst) begin
            r_enable <= '0;
        end else if (w_enable_wr) begin
            r_enable <= i_riscv_core_plic_wdata[NSRC-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Handshake FSM. mexternal comes straight from its own flop so the
    // request line cannot glitch while the state bits change.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_riscv_core_clk or posedge i_riscv_core_rst) begin
        if (i_riscv_core_rst) begin
            r_state    <= ST_IDLE;
            r_mext     <= 1'b0;
            r_claim_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_any) begin
                        r_state <= ST_REQ;
                        r_mext  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_claim) begin
                        r_claim_id <= w_win_idx + ID_W'(1);
                        r_state    <= ST_SERVICE;
                        r_mext     <= 1'b0;
                    end else if (!w_win_any) begin
                        // Request withdrawn because its enable was cleared.
                        r_state <= ST_IDLE;
                        r_mext  <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (w_complete) begin
                        r_claim_id <= '0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_mext  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read port: registered, no side effects
    // ------------------------------------------------------------------------
    always_ff @(posedge i_riscv_core_clk or posedge i_riscv_core_rst) begin
        if (i_riscv_core_rst) begin
            r_rdata <= '0;
        end else begin
            case (i_riscv_core_plic_addr)
                c_ADDR_PENDING: r_rdata <= {{(32-NSRC){1'b0}}, r_pending};
                c_ADDR_ENABLE:  r_rdata <= {{(32-NSRC){1'b0}}, r_enable};
                c_ADDR_CLAIM:   r_rdata <= {{(32-ID_W){1'b0}}, r_claim_id};
                c_ADDR_STATUS:  r_rdata <= {30'd0, r_state};
                default:        r_rdata <= '0;
            endcase
        end
    end

    assign o_riscv_core_mexternal  = r_mext;
    assign o_riscv_core_plic_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_plic_lite.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_core_plic_lite
// Description : Self-checking bench for riscv_core_plic_lite. Register reads
//               push their expected value into a queue when the address is
//               driven and pop it when the registered read data appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_core_plic_lite;

    localparam int NSRC = 8;

    logic            clk;
    logic            rst;
    logic [NSRC-1:0] src;
    logic            mext;
    logic            ack;
    logic [1:0]      addr;
    logic            wen;
    logic [31:0]     wdata;
    logic [31:0]     rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_exp [$];

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    riscv_core_plic_lite #(.NSRC(NSRC), .SYNC_STAGES(2)) dut (
        .i_riscv_core_clk        (clk),
        .i_riscv_core_rst        (rst),
        .i_riscv_core_irq_src    (src),
        .o_riscv_core_mexternal  (mext),
        .i_riscv_core_ack        (ack),
        .i_riscv_core_plic_addr  (addr),
        .i_riscv_core_plic_wen   (wen),
        .i_riscv_core_plic_wdata (wdata),
        .o_riscv_core_plic_rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        addr = a;
        q_exp.push_back(exp);
        tick();
        e = q_exp.pop_front();
        chk(name, rdata, e);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        tick();
        wen   = 1'b0;
        wdata = '0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_mext(input logic val, input int budget, input string name);
        int n = 0;
        while (mext !== val && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, mext}, {31'd0, val});
    endtask

    initial begin
        vecs[0] = '{waddr: 2'd1, wdata: 32'hFFFF_FF5A, raddr: 2'd1, exp: 32'h0000_005A};
        vecs[1] = '{waddr: 2'd1, wdata: 32'h0000_0100, raddr: 2'd1, exp: 32'h0000_0000};
        vecs[2] = '{waddr: 2'd1, wdata: 32'h0000_00A5, raddr: 2'd1, exp: 32'h0000_00A5};
        vecs[3] = '{waddr: 2'd0, wdata: 32'hFFFF_FFFF, raddr: 2'd0, exp: 32'h0000_0000};
        vecs[4] = '{waddr: 2'd3, wdata: 32'hFFFF_FFFF, raddr: 2'd3, exp: 32'h0000_0000};
        vecs[5] = '{waddr: 2'd2, wdata: 32'hFFFF_FFFF, raddr: 2'd2, exp: 32'h0000_0000};
        vecs[6] = '{waddr: 2'd1, wdata: 32'h0000_0000, raddr: 2'd1, exp: 32'h0000_0000};

        rst = 1'b1; src = '0; ack = 1'b0; addr = '0; wen = 1'b0; wdata = '0;
        #1;
        chk("reset_mext", {31'd0, mext}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        rd(2'd3, 32'd0, "reset_status");

        // Register port vectors (no sources active)
        for (int i = 0; i < 7; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
        end
        chk("vec_no_req", {31'd0, mext}, 32'd0);

        // Single source latency
        wr(2'd1, 32'h04);
        src = 8'h04;
        tick();                              // edge k
        tick();                              // edge k+1
        tick();                              // edge k+2 : pending set
        chk("lat_mext_k2", {31'd0, mext}, 32'd0);
        tick();                              // edge k+3 : request
        chk("lat_mext_k3", {31'd1, 1'b1} & 32'd1 & {31'd0, mext}, 32'd1);
        rd(2'd0, 32'h04, "lat_pending");
        chk("lat_mext_hold", {31'd0, mext}, 32'd1);
        ack_pulse();
        chk("lat_mext_ack", {31'd0, mext}, 32'd0);
        rd(2'd2, 32'd3, "lat_claim");
        rd(2'd0, 32'd0, "lat_pending_clr");
        rd(2'd3, 32'd2, "lat_status_svc");
        wr(2'd2, 32'd0);
        rd(2'd3, 32'd0, "lat_status_idle");
        rd(2'd2, 32'd0, "lat_claim_clr");
        src = '0;
        tick(); tick(); tick();

        // Priority
        wr(2'd1, 32'hFF);
        src = 8'h90;
        wait_mext(1'b1, 10, "prio_req1");
        ack_pulse();
        rd(2'd2, 32'd5, "prio_claim1");
        wr(2'd2, 32'd0);
        wait_mext(1'b1, 4, "prio_req2");
        ack_pulse();
        rd(2'd2, 32'd8, "prio_claim2");
        wr(2'd2, 32'd0);
        src = '0;
        tick(); tick(); tick();
        chk("prio_idle", {31'd0, mext}, 32'd0);

        // Masking
        wr(2'd1, 32'h00);
        src = 8'h02;
        tick(); tick(); tick(); tick();
        chk("mask_no_req", {31'd0, mext}, 32'd0);
        rd(2'd0, 32'h02, "mask_pending");
        wr(2'd1, 32'h02);
        wait_mext(1'b1, 4, "mask_req");
        wr(2'd1, 32'h00);
        wait_mext(1'b0, 4, "mask_withdraw");
        rd(2'd3, 32'd0, "mask_status");
        rd(2'd0, 32'h02, "mask_pending_kept");

        // Stray handshake: ack in IDLE, COMPLETE in REQ
        ack_pulse();
        tick();
        rd(2'd3, 32'd0, "stray_ack_status");
        rd(2'd0, 32'h02, "stray_ack_pending");
        rd(2'd2, 32'd0, "stray_ack_claim");
        wr(2'd1, 32'h02);
        wait_mext(1'b1, 4, "stray_req");
        wr(2'd2, 32'd0);
        rd(2'd3, 32'd1, "stray_cpl_status");
        rd(2'd0, 32'h02, "stray_cpl_pending");
        rd(2'd2, 32'd0, "stray_cpl_claim");
        chk("stray_cpl_mext", {31'd0, mext}, 32'd1);
        ack_pulse();
        rd(2'd2, 32'd2, "stray_claim");
        wr(2'd2, 32'd0);
        src = '0;
        tick(); tick(); tick();

        // Held level and re-arm
        wr(2'd1, 32'h01);
        src = 8'h01;
        wait_mext(1'b1, 6, "held_req1");
        ack_pulse();
        rd(2'd2, 32'd1, "held_claim");
        wr(2'd2, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("held_no_rereq", {31'd0, mext}, 32'd0);
        rd(2'd0, 32'd0, "held_pending");
        rd(2'd3, 32'd0, "held_status");
        src = '0;
        tick(); tick(); tick();
        src = 8'h01;
        wait_mext(1'b1, 6, "held_rearm");
        rd(2'd0, 32'h01, "held_rearm_pending");

        // Asynchronous reset in REQ
        rst = 1'b1;
        src = '0;
        #1;
        chk("arst_mext", {31'd0, mext}, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        rd(2'd0, 32'd0, "arst_pending");
        rd(2'd1, 32'd0, "arst_enable");
        rd(2'd2, 32'd0, "arst_claim");
        rd(2'd3, 32'd0, "arst_status");
        tick(); tick(); tick();
        chk("arst_mext_after", {31'd0, mext}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
